// File: rtl/stack_based_alu.sv
// LIFO operand stack with in-place signed add/multiply reduction; one opcode per clock.
// Latency 1: output_data/overflow register on the edge that samples the opcode; no handshake.
module stack_based_alu #(
    parameter int n     = 32,
    parameter int DEPTH = 1024
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [n-1:0] i_input_data,
    input  logic [2:0]   i_opcode,
    output logic [n-1:0] o_output_data,
    output logic         o_overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    logic [n-1:0]    r_stack [DEPTH];
    logic [CW-1:0]   r_count;
    logic [n-1:0]    r_output_data;
    logic            r_overflow;

    logic [AW-1:0]   w_idx_a;
    logic [AW-1:0]   w_idx_b;
    logic [AW-1:0]   w_idx_push;
    logic [n-1:0]    w_a;
    logic [n-1:0]    w_b;
    logic [n-1:0]    w_sum;
    logic            w_sum_ovf;
    logic [2*n-1:0]  w_prod;
    logic            w_prod_ovf;
    logic            w_has_two;
    logic            w_has_one;
    logic            w_has_room;
    logic            w_do_reduce;
    logic [n-1:0]    w_result;
    logic            w_result_ovf;

    // A is the top entry (count-1), B the one beneath it (count-2).
    assign w_idx_a    = AW'(r_count - CW'(1));
    assign w_idx_b    = AW'(r_count - CW'(2));
    assign w_idx_push = AW'(r_count);
    assign w_a        = r_stack[w_idx_a];
    assign w_b        = r_stack[w_idx_b];

    assign w_has_two  = (r_count >= CW'(2));
    assign w_has_one  = (r_count != '0);
    assign w_has_room = (r_count < CW'(DEPTH));

    assign w_sum      = w_b + w_a;
    assign w_sum_ovf  = (w_a[n-1] == w_b[n-1]) && (w_sum[n-1] != w_a[n-1]);

    assign w_prod     = $signed({{n{w_b[n-1]}}, w_b}) * $signed({{n{w_a[n-1]}}, w_a});
    assign w_prod_ovf = (w_prod[2*n-1:n] != {n{w_prod[n-1]}});

    assign w_do_reduce  = ((i_opcode == OP_ADD) || (i_opcode == OP_MUL)) && w_has_two;
    assign w_result     = (i_opcode == OP_MUL) ? w_prod[n-1:0] : w_sum;
    assign w_result_ovf = (i_opcode == OP_MUL) ? w_prod_ovf : w_sum_ovf;

    // Storage has no reset; only entries below r_count are ever meaningful.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_do_reduce) begin
                r_stack[w_idx_b] <= w_result;
            end else if ((i_opcode == OP_PUSH) && w_has_room) begin
                r_stack[w_idx_push] <= i_input_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count       <= '0;
            r_output_data <= '0;
            r_overflow    <= 1'b0;
        end else begin
            case (i_opcode)
                OP_ADD, OP_MUL: begin
                    if (w_has_two) begin
                        r_count       <= r_count - CW'(1);
                        r_output_data <= w_result;
                        r_overflow    <= w_result_ovf;
                    end
                end
                OP_PUSH: begin
                    if (w_has_room) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                OP_POP: begin
                    if (w_has_one) begin
                        r_count       <= r_count - CW'(1);
                        r_output_data <= w_a;
                        r_overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_output_data = r_output_data;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_stack_based_alu.sv
// Directed plus random opcode stream for stack_based_alu, checked against a queue-based model.
module tb_stack_based_alu;
    localparam int N     = 32;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] input_data;
    logic [2:0]   opcode;
    logic [N-1:0] output_data;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    int q[$];
    int m_out;
    bit m_ovf;

    stack_based_alu #(.n(N), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_input_data  (input_data),
        .i_opcode      (opcode),
        .o_output_data (output_data),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic model(input logic r, input logic [2:0] op, input logic [N-1:0] d);
        int     a, b, res;
        longint s;
        if (r) begin
            q.delete();
            m_out = 0;
            m_ovf = 0;
        end else if (op[2]) begin
            case (op[1:0])
                2'b00, 2'b01: begin
                    if (q.size() >= 2) begin
                        a = q.pop_back();
                        b = q.pop_back();
                        if (op[0]) s = longint'(b) * longint'(a);
                        else       s = longint'(b) + longint'(a);
                        res = int'(s);
                        q.push_back(res);
                        m_out = res;
                        m_ovf = (s != longint'(res));
                    end
                end
                2'b10: if (q.size() < DEPTH) q.push_back(int'(d));
                default: begin
                    if (q.size() > 0) begin
                        m_out = q.pop_back();
                        m_ovf = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag);
        tests++;
        assert (output_data === m_out) else begin
            fails++;
            $error("FAIL %s data got %h exp %h", tag, output_data, m_out);
        end
        tests++;
        assert (overflow === m_ovf) else begin
            fails++;
            $error("FAIL %s ovf got %b exp %b", tag, overflow, m_ovf);
        end
    endtask

    task automatic check_const(input string tag, input logic [N-1:0] exp_d, input logic exp_o);
        tests++;
        assert (output_data === exp_d) else begin
            fails++;
            $error("FAIL %s const data got %h exp %h", tag, output_data, exp_d);
        end
        tests++;
        assert (overflow === exp_o) else begin
            fails++;
            $error("FAIL %s const ovf got %b exp %b", tag, overflow, exp_o);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] op, input logic [N-1:0] d, input string tag);
        @(negedge clk);
        rst        = r;
        opcode     = op;
        input_data = d;
        @(posedge clk);
        model(r, op, d);
        #1;
        check(tag);
    endtask

    task automatic push(input logic [N-1:0] d);
        step(1'b0, 3'b110, d, "push");
    endtask

    function automatic logic [N-1:0] rand_data();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0001_0000;
            3:       return N'($urandom_range(0, 20)) - 32'd10;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        logic [2:0] op;
        rst = 1'b1; opcode = 3'b000; input_data = '0;
        step(1'b1, 3'b000, '0, "reset");
        check_const("reset", 32'd0, 1'b0);

        push(2); push(3);
        step(1'b0, 3'b100, '0, "add");
        check_const("add5", 32'd5, 1'b0);
        step(1'b0, 3'b111, '0, "pop5");
        check_const("pop5", 32'd5, 1'b0);
        step(1'b0, 3'b111, '0, "pop_empty");
        step(1'b0, 3'b100, '0, "add_empty");
        step(1'b0, 3'b101, '0, "mul_empty");
        check_const("empty_hold", 32'd5, 1'b0);

        push(2); push(3);
        step(1'b0, 3'b101, '0, "mul6");
        push(17); push(-32'sd20);
        step(1'b0, 3'b101, '0, "mul_neg");
        step(1'b0, 3'b100, '0, "add_mix");
        check_const("expr", -32'sd334, 1'b0);
        step(1'b0, 3'b111, '0, "pop_expr");

        push(32'h7FFF_FFFF); push(1);
        step(1'b0, 3'b100, '0, "add_ovf");
        check_const("add_ovf", 32'h8000_0000, 1'b1);
        step(1'b0, 3'b011, '0, "nop_hold");
        step(1'b0, 3'b111, '0, "pop_clr");
        check_const("pop_clr", 32'h8000_0000, 1'b0);

        push(32'h0001_0000); push(32'h0001_0000);
        step(1'b0, 3'b101, '0, "mul_ovf");
        check_const("mul_ovf", 32'd0, 1'b1);
        push(-32'sd4); push(5);
        step(1'b0, 3'b101, '0, "mul_m20");
        check_const("mul_m20", -32'sd20, 1'b0);
        step(1'b0, 3'b111, '0, "pop_a");
        step(1'b0, 3'b111, '0, "pop_b");

        for (int i = 0; i < DEPTH; i++) push(N'(100 + i));
        push(999);
        step(1'b0, 3'b111, '0, "pop_full");
        check_const("pop_full", N'(100 + DEPTH - 1), 1'b0);

        push(7);
        step(1'b1, 3'b110, 9, "rst_push");
        check_const("rst_mid", 32'd0, 1'b0);
        step(1'b0, 3'b111, '0, "pop_after_rst");
        check_const("pop_after_rst", 32'd0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:          op = 3'($urandom_range(0, 3));
                1, 2, 3, 4: op = 3'b110;
                5:          op = 3'b100;
                6:          op = 3'b101;
                7, 8:       op = 3'b111;
                default:    op = 3'($urandom_range(4, 7));
            endcase
            step(($urandom_range(0, 99) == 0), op, rand_data(), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
